// File: rtl/issue_queue.sv
// Reservation station: age-ordered compacting queue with tag wakeup from
// NUM_WB writeback buses and oldest-ready dispatch to one functional unit.

// Per-source wakeup lane: captures a writeback result whose tag matches a
// pending source. Lowest bus index wins when several buses match.
module issue_queue_wake #(
  parameter int XLEN   = 32,
  parameter int NUM_WB = 3,
  parameter int TAG_W  = 5
) (
  input  logic                    rdy,
  input  logic [TAG_W-1:0]        tag,
  input  logic [XLEN-1:0]         data,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  input  logic [NUM_WB*XLEN-1:0]  wb_data,
  output logic                    nrdy,
  output logic [XLEN-1:0]         ndata
);
  // scan high to low so the lowest matching bus is the last writer
  always_comb begin
    nrdy  = rdy;
    ndata = data;
    if (!rdy) begin
      for (int b = NUM_WB-1; b >= 0; b--) begin
        if (wb_valid[b] && wb_tag[b*TAG_W +: TAG_W] == tag) begin
          nrdy  = 1'b1;
          ndata = wb_data[b*XLEN +: XLEN];
        end
      end
    end
  end
endmodule

module issue_queue #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int NUM_WB = 3,
  parameter int TAG_W  = 5,
  parameter int OP_W   = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OP_W-1:0]              in_op,
  input  logic [TAG_W-1:0]             in_rd,
  input  logic                         in_s1_rdy,
  input  logic [TAG_W-1:0]             in_s1_tag,
  input  logic [XLEN-1:0]              in_s1_data,
  input  logic                         in_s2_rdy,
  input  logic [TAG_W-1:0]             in_s2_tag,
  input  logic [XLEN-1:0]              in_s2_data,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]      wb_tag,
  input  logic [NUM_WB*XLEN-1:0]       wb_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OP_W-1:0]              out_op,
  output logic [TAG_W-1:0]             out_rd,
  output logic [XLEN-1:0]              out_op1,
  output logic [XLEN-1:0]              out_op2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] rd;
    logic             s1_rdy;
    logic [TAG_W-1:0] s1_tag;
    logic [XLEN-1:0]  s1_data;
    logic             s2_rdy;
    logic [TAG_W-1:0] s2_tag;
    logic [XLEN-1:0]  s2_data;
  } ent_t;

  ent_t [DEPTH-1:0]            q, sh;
  ent_t [DEPTH:0]              ext;
  ent_t                        req;
  logic [DEPTH-1:0]            w1_rdy, w2_rdy;
  logic [DEPTH-1:0][XLEN-1:0]  w1_data, w2_data;
  logic                        found, do_disp, do_enq;
  logic [IW-1:0]               sel;
  logic [CW-1:0]               slot;

  assign req = '{op: in_op, rd: in_rd,
                 s1_rdy: in_s1_rdy, s1_tag: in_s1_tag, s1_data: in_s1_data,
                 s2_rdy: in_s2_rdy, s2_tag: in_s2_tag, s2_data: in_s2_data};
  // one zero entry above the top so the shift source index never runs off
  assign ext = {ent_t'('0), q};

  // oldest occupied entry with both sources ready, from registered state only
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (CW'(i) < count && q[i].s1_rdy && q[i].s2_rdy) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = found & ~flush & ~rst;
  assign do_disp   = out_valid & out_ready;
  assign do_enq    = in_valid & in_ready & ~flush & ~rst;
  // a same-cycle dispatch frees one slot below the current tail
  assign slot      = count - CW'(do_disp);

  assign out_op  = out_valid ? q[sel].op      : '0;
  assign out_rd  = out_valid ? q[sel].rd      : '0;
  assign out_op1 = out_valid ? q[sel].s1_data : '0;
  assign out_op2 = out_valid ? q[sel].s2_data : '0;

  // compaction above the dispatched entry, then new instruction at the tail
  always_comb begin
    sh = q;
    for (int i = 0; i < DEPTH; i++) begin
      if (do_disp && IW'(i) >= sel) sh[i] = ext[i+1];
      if (do_enq && slot == CW'(i)) sh[i] = req;
    end
  end

  // wakeup runs on post-shift contents so moving and arriving entries capture too
  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    issue_queue_wake #(.XLEN(XLEN), .NUM_WB(NUM_WB), .TAG_W(TAG_W)) u_w1 (
      .rdy(sh[i].s1_rdy), .tag(sh[i].s1_tag), .data(sh[i].s1_data),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
      .nrdy(w1_rdy[i]), .ndata(w1_data[i]));
    issue_queue_wake #(.XLEN(XLEN), .NUM_WB(NUM_WB), .TAG_W(TAG_W)) u_w2 (
      .rdy(sh[i].s2_rdy), .tag(sh[i].s2_tag), .data(sh[i].s2_data),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
      .nrdy(w2_rdy[i]), .ndata(w2_data[i]));
  end

  // entry storage and occupancy; flush clears like reset
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      q     <= '0;
    end else begin
      count <= count + CW'(do_enq) - CW'(do_disp);
      for (int i = 0; i < DEPTH; i++) begin
        q[i]         <= sh[i];
        q[i].s1_rdy  <= w1_rdy[i];
        q[i].s1_data <= w1_data[i];
        q[i].s2_rdy  <= w2_rdy[i];
        q[i].s2_data <= w2_data[i];
      end
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Random + directed bench for issue_queue with a queue-based reference model
// and a scoreboard of expected dispatches checked by a separate monitor.
module tb_issue_queue;
  localparam int XLEN = 32, DEPTH = 4, NUM_WB = 3, TAG_W = 5, OP_W = 6;
  localparam int CW = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, in_s1_rdy, in_s2_rdy, out_valid, out_ready;
  logic [OP_W-1:0]  in_op, out_op;
  logic [TAG_W-1:0] in_rd, in_s1_tag, in_s2_tag, out_rd;
  logic [XLEN-1:0]  in_s1_data, in_s2_data, out_op1, out_op2;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic [NUM_WB*XLEN-1:0]  wb_data;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  issue_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_WB(NUM_WB), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd),
    .in_s1_rdy(in_s1_rdy), .in_s1_tag(in_s1_tag), .in_s1_data(in_s1_data),
    .in_s2_rdy(in_s2_rdy), .in_s2_tag(in_s2_tag), .in_s2_data(in_s2_data),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
    .out_op1(out_op1), .out_op2(out_op2), .count(count));

  typedef struct {
    logic [OP_W-1:0] op; logic [TAG_W-1:0] rd;
    logic r1; logic [TAG_W-1:0] t1; logic [XLEN-1:0] d1;
    logic r2; logic [TAG_W-1:0] t2; logic [XLEN-1:0] d2;
  } ins_t;
  typedef struct { logic [OP_W-1:0] op; logic [TAG_W-1:0] rd; logic [XLEN-1:0] a, b; } res_t;
  typedef struct {
    logic rst, flush, in_valid, out_ready;
    ins_t ins;
    logic [NUM_WB-1:0] wv; logic [NUM_WB*TAG_W-1:0] wt; logic [NUM_WB*XLEN-1:0] wd;
  } stim_t;

  ins_t mq[$];
  res_t exp_q[$];
  int   checks = 0, errors = 0;
  int   cand = -1;
  bit   exp_valid = 0;

  // first writeback bus carrying tag t, if any
  function automatic bit bus_hit(input logic [TAG_W-1:0] t, output logic [XLEN-1:0] d);
    d = '0;
    for (int b = 0; b < NUM_WB; b++)
      if (wb_valid[b] && wb_tag[b*TAG_W +: TAG_W] == t) begin
        d = wb_data[b*XLEN +: XLEN];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic int oldest_ready();
    for (int i = 0; i < mq.size(); i++) if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  // advance the reference model using the inputs held across this edge
  task automatic model_update();
    logic [XLEN-1:0] d;
    bit enq;
    if (rst || flush) mq.delete();
    else begin
      enq = in_valid && (mq.size() < DEPTH);
      if (cand >= 0 && out_ready) mq.delete(cand);
      if (enq) mq.push_back('{in_op, in_rd, in_s1_rdy, in_s1_tag, in_s1_data,
                              in_s2_rdy, in_s2_tag, in_s2_data});
      for (int k = 0; k < mq.size(); k++) begin
        if (!mq[k].r1 && bus_hit(mq[k].t1, d)) begin mq[k].r1 = 1'b1; mq[k].d1 = d; end
        if (!mq[k].r2 && bus_hit(mq[k].t2, d)) begin mq[k].r2 = 1'b1; mq[k].d2 = d; end
      end
    end
  endtask

  task automatic apply(input stim_t s);
    rst = s.rst; flush = s.flush; in_valid = s.in_valid; out_ready = s.out_ready;
    in_op = s.ins.op; in_rd = s.ins.rd;
    in_s1_rdy = s.ins.r1; in_s1_tag = s.ins.t1; in_s1_data = s.ins.d1;
    in_s2_rdy = s.ins.r2; in_s2_tag = s.ins.t2; in_s2_data = s.ins.d2;
    wb_valid = s.wv; wb_tag = s.wt; wb_data = s.wd;
    cand = (rst || flush) ? -1 : oldest_ready();
    exp_valid = (cand >= 0);
    if (exp_valid && out_ready)
      exp_q.push_back('{mq[cand].op, mq[cand].rd, mq[cand].d1, mq[cand].d2});
  endtask

  task automatic drive(input stim_t s);
    @(posedge clk);
    model_update();
    #1;
    apply(s);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.ins = '{default: '0};
    s.out_ready = 1'b1;
    return s;
  endfunction

  function automatic ins_t mk(input int op, rd, r1, t1, d1, r2, t2, d2);
    ins_t i;
    i = '{OP_W'(op), TAG_W'(rd), r1[0], TAG_W'(t1), XLEN'(d1), r2[0], TAG_W'(t2), XLEN'(d2)};
    return i;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s = idle();
    s.rst = ($urandom_range(199) == 0);
    s.flush = ($urandom_range(39) == 0);
    s.in_valid = ($urandom_range(9) < 6);
    s.out_ready = ($urandom_range(9) < 7);
    s.ins = mk($urandom_range(63), $urandom_range(31), $urandom_range(1), $urandom_range(7),
               $urandom, $urandom_range(1), $urandom_range(7), $urandom);
    for (int b = 0; b < NUM_WB; b++) begin
      s.wv[b] = ($urandom_range(2) == 0);
      s.wt[b*TAG_W +: TAG_W] = TAG_W'($urandom_range(7));
      s.wd[b*XLEN +: XLEN] = $urandom;
    end
    return s;
  endfunction

  // monitor: occupancy, handshake and scoreboard pop on every accepted dispatch
  always @(negedge clk) begin
    res_t e;
    checks++;
    if (count !== CW'(mq.size())) begin
      errors++; $display("FAIL count got %0d exp %0d", count, mq.size());
    end
    checks++;
    if (in_ready !== (mq.size() < DEPTH)) begin
      errors++; $display("FAIL in_ready got %b exp %b", in_ready, mq.size() < DEPTH);
    end
    checks++;
    if (out_valid !== exp_valid) begin
      errors++; $display("FAIL out_valid got %b exp %b", out_valid, exp_valid);
    end
    if (out_valid === 1'b0) begin
      checks++;
      if ({out_op, out_rd, out_op1, out_op2} !== '0) begin
        errors++; $display("FAIL idle_outs got %h/%h/%h/%h exp 0", out_op, out_rd, out_op1, out_op2);
      end
    end else if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL dispatch got rd=%0d exp none", out_rd);
      end else begin
        e = exp_q.pop_front();
        if (out_op !== e.op || out_rd !== e.rd || out_op1 !== e.a || out_op2 !== e.b) begin
          errors++;
          $display("FAIL dispatch got op=%h rd=%0d a=%h b=%h exp op=%h rd=%0d a=%h b=%h",
                   out_op, out_rd, out_op1, out_op2, e.op, e.rd, e.a, e.b);
        end
      end
    end
  end

  initial begin
    stim_t s;
    s = idle(); s.rst = 1'b1;
    apply(s);
    drive(s); drive(s);
    // single ready instruction dispatches next cycle
    s = idle(); s.in_valid = 1'b1; s.ins = mk(1, 3, 1, 0, 5, 1, 0, 7);
    drive(s); drive(idle()); drive(idle());
    // waiting A overtaken by ready B, then A woken by bus 0
    s = idle(); s.in_valid = 1'b1; s.ins = mk(2, 10, 0, 4, 0, 1, 0, 22);
    drive(s);
    s.ins = mk(3, 11, 1, 0, 33, 1, 0, 44);
    drive(s);
    s = idle(); s.wv = 3'b001; s.wt[0 +: TAG_W] = 5'd4; s.wd[0 +: XLEN] = 32'h1234;
    drive(s); drive(idle()); drive(idle());
    // fill to DEPTH with the FU stalled; fifth is dropped
    for (int k = 0; k < 5; k++) begin
      s = idle(); s.out_ready = 1'b0; s.in_valid = 1'b1; s.ins = mk(k, 20+k, 1, 0, k, 1, 0, 100+k);
      drive(s);
    end
    s = idle(); s.out_ready = 1'b0;
    drive(s);
    drive(idle());
    s = idle(); s.out_ready = 1'b0;
    drive(s);
    for (int k = 0; k < 4; k++) drive(idle());
    // same-cycle capture on the arriving entry from bus 2
    s = idle(); s.in_valid = 1'b1; s.ins = mk(5, 7, 1, 0, 1, 0, 9, 0);
    s.wv = 3'b100; s.wt[2*TAG_W +: TAG_W] = 5'd9; s.wd[2*XLEN +: XLEN] = 32'hBEEF;
    drive(s); drive(idle()); drive(idle());
    // flush beats enqueue and dispatch
    for (int k = 0; k < 3; k++) begin
      s = idle(); s.out_ready = 1'b0; s.in_valid = 1'b1; s.ins = mk(k, k, 1, 0, k, 1, 0, k);
      drive(s);
    end
    s = idle(); s.flush = 1'b1; s.in_valid = 1'b1; s.ins = mk(9, 9, 1, 0, 9, 1, 0, 9);
    drive(s); drive(idle()); drive(idle());
    // randomized traffic
    for (int n = 0; n < 3000; n++) drive(rnd());
    s = idle(); s.flush = 1'b1;
    drive(s); drive(idle()); drive(idle());
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
